// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: load / compute / output sequencer for a
// valid-length 1-D correlation over x and f sample memories.
module conv_seq_ctrl #(
  parameter int X_LEN = 112,
  parameter int F_LEN = 49,
  localparam int XA = (X_LEN > 1) ? $clog2(X_LEN) : 1,
  localparam int FA = (F_LEN > 1) ? $clog2(F_LEN) : 1,
  localparam int Y_LEN = X_LEN - F_LEN + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          x_valid,
  output logic          x_ready,
  input  logic          f_valid,
  output logic          f_ready,
  input  logic          y_ready,
  output logic          y_valid,
  output logic [XA-1:0] addr_x,
  output logic          wr_en_x,
  output logic [FA-1:0] addr_f,
  output logic          wr_en_f,
  output logic          clear_acc,
  output logic          en_acc
);

  typedef enum logic [1:0] {
    LOAD,
    COMPUTE,
    OUTPUT
  } state_t;

  localparam logic [XA:0]   X_FULL = (XA+1)'(X_LEN);
  localparam logic [FA:0]   F_FULL = (FA+1)'(F_LEN);
  localparam logic [FA-1:0] F_LAST = FA'(F_LEN - 1);
  localparam logic [XA-1:0] B_LAST = XA'(Y_LEN - 1);

  state_t        state_q, state_d;
  logic [XA:0]   xcnt_q, xcnt_d;
  logic [FA:0]   fcnt_q, fcnt_d;
  logic [XA-1:0] base_q, base_d;
  logic [FA:0]   k_q, k_d;
  logic          k_end;
  logic [FA-1:0] k_addr;

  // k runs 0..F_LEN; the extra cycle drains the read
  // latency, so addresses stay parked on the last tap.
  assign k_end  = (k_q == F_FULL);
  assign k_addr = k_end ? F_LAST : k_q[FA-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD;
      xcnt_q  <= '0;
      fcnt_q  <= '0;
      base_q  <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      xcnt_q  <= xcnt_d;
      fcnt_q  <= fcnt_d;
      base_q  <= base_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    xcnt_d    = xcnt_q;
    fcnt_d    = fcnt_q;
    base_d    = base_q;
    k_d       = k_q;
    x_ready   = 1'b0;
    f_ready   = 1'b0;
    wr_en_x   = 1'b0;
    wr_en_f   = 1'b0;
    y_valid   = 1'b0;
    clear_acc = 1'b0;
    en_acc    = 1'b0;
    addr_x    = base_q + XA'(k_addr);
    addr_f    = k_addr;
    unique case (state_q)
      LOAD: begin
        x_ready   = (xcnt_q < X_FULL);
        f_ready   = (fcnt_q < F_FULL);
        wr_en_x   = x_valid & x_ready;
        wr_en_f   = f_valid & f_ready;
        addr_x    = x_ready ? xcnt_q[XA-1:0] : '0;
        addr_f    = f_ready ? fcnt_q[FA-1:0] : '0;
        clear_acc = 1'b1;
        xcnt_d    = xcnt_q + (XA+1)'(wr_en_x);
        fcnt_d    = fcnt_q + (FA+1)'(wr_en_f);
        if (xcnt_d == X_FULL && fcnt_d == F_FULL) begin
          state_d = COMPUTE;
          k_d     = '0;
        end
      end
      COMPUTE: begin
        en_acc = (k_q != '0);
        if (k_end) begin
          state_d = OUTPUT;
        end else begin
          k_d = k_q + (FA+1)'(1);
        end
      end
      OUTPUT: begin
        y_valid = 1'b1;
        if (y_ready) begin
          clear_acc = 1'b1;
          k_d       = '0;
          if (base_q == B_LAST) begin
            state_d = LOAD;
            base_d  = '0;
            xcnt_d  = '0;
            fcnt_d  = '0;
          end else begin
            state_d = COMPUTE;
            base_d  = base_q + XA'(1);
          end
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// tb_conv_seq_ctrl: directed vectors against a bench-side
// memory + MAC model steered by the sequencer outputs.
module tb_conv_seq_ctrl;

  localparam int XL = 8;
  localparam int FL = 3;
  localparam int YL = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic x_valid, x_ready, f_valid, f_ready;
  logic y_ready, y_valid;
  logic [2:0] addr_x;
  logic [1:0] addr_f;
  logic wr_en_x, wr_en_f, clear_acc, en_acc;
  logic signed [7:0] x_data, f_data;

  conv_seq_ctrl #(.X_LEN(XL), .F_LEN(FL)) dut (
    .clk(clk), .reset(reset),
    .x_valid(x_valid), .x_ready(x_ready),
    .f_valid(f_valid), .f_ready(f_ready),
    .y_ready(y_ready), .y_valid(y_valid),
    .addr_x(addr_x), .wr_en_x(wr_en_x),
    .addr_f(addr_f), .wr_en_f(wr_en_f),
    .clear_acc(clear_acc), .en_acc(en_acc)
  );

  logic b_x_valid, b_x_ready, b_f_valid, b_f_ready;
  logic b_y_ready, b_y_valid;
  logic [1:0] b_ax, b_af;
  logic b_wx, b_wf, b_clr, b_en;
  logic signed [7:0] b_xd, b_fd;

  conv_seq_ctrl #(.X_LEN(4), .F_LEN(4)) dut_b (
    .clk(clk), .reset(reset),
    .x_valid(b_x_valid), .x_ready(b_x_ready),
    .f_valid(b_f_valid), .f_ready(b_f_ready),
    .y_ready(b_y_ready), .y_valid(b_y_valid),
    .addr_x(b_ax), .wr_en_x(b_wx),
    .addr_f(b_af), .wr_en_f(b_wf),
    .clear_acc(b_clr), .en_acc(b_en)
  );

  // memories with 1-cycle read latency and a MAC
  logic signed [7:0] xmem [8];
  logic signed [7:0] fmem [4];
  logic signed [7:0] xrd, frd;
  logic signed [31:0] acc;

  always_ff @(posedge clk) begin
    if (wr_en_x) xmem[addr_x] <= x_data;
    if (wr_en_f) fmem[addr_f] <= f_data;
    xrd <= xmem[addr_x];
    frd <= fmem[addr_f];
    if (clear_acc) acc <= '0;
    else if (en_acc) acc <= acc + 32'(xrd * frd);
  end

  logic signed [7:0] bxm [4];
  logic signed [7:0] bfm [4];
  logic signed [7:0] bxr, bfr;
  logic signed [31:0] b_acc;

  always_ff @(posedge clk) begin
    if (b_wx) bxm[b_ax] <= b_xd;
    if (b_wf) bfm[b_af] <= b_fd;
    bxr <= bxm[b_ax];
    bfr <= bfm[b_af];
    if (b_clr) b_acc <= '0;
    else if (b_en) b_acc <= b_acc + 32'(bxr * bfr);
  end

  int nvec = 0;
  int nerr = 0;

  logic signed [7:0] xs [XL];
  logic signed [7:0] fs [FL];
  int ye [YL];

  task automatic check(input string tag, input longint got,
                       input longint exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rst(input string tag);
    check({tag, "_x_rdy"}, x_ready, 1);
    check({tag, "_f_rdy"}, f_ready, 1);
    check({tag, "_yv"}, y_valid, 0);
    check({tag, "_en"}, en_acc, 0);
    check({tag, "_clr"}, clear_acc, 1);
    check({tag, "_wx"}, wr_en_x, 0);
    check({tag, "_wf"}, wr_en_f, 0);
    check({tag, "_ax"}, addr_x, 0);
    check({tag, "_af"}, addr_f, 0);
  endtask

  // x = 1..8, f = 1,0,-1 -> every y is x[b] - x[b+2] = -2
  task automatic set1();
    for (int i = 0; i < XL; i++) xs[i] = 8'(i + 1);
    fs[0] = 8'sd1;
    fs[1] = 8'sd0;
    fs[2] = -8'sd1;
    for (int i = 0; i < YL; i++) ye[i] = -2;
  endtask

  // x = 8..1, f = 1,1,1 -> 21,18,15,12,9,6
  task automatic set2();
    for (int i = 0; i < XL; i++) xs[i] = 8'(XL - i);
    for (int i = 0; i < FL; i++) fs[i] = 8'sd1;
    for (int i = 0; i < YL; i++) ye[i] = 21 - 3 * i;
  endtask

  task automatic run_load(input bit ffirst, input bit gaps);
    int xi = 0;
    int fi = 0;
    int t = 0;
    while ((xi < XL || fi < FL) && t < 200) begin
      f_valid = (fi < FL);
      f_data  = fs[fi % FL];
      x_valid = (xi < XL) && (!ffirst || fi == FL) &&
                !(gaps && $urandom_range(0, 2) == 0);
      x_data  = xs[xi % XL];
      #1;
      if (xi == XL) check("x_full", x_ready, 0);
      if (fi == FL) check("f_full", f_ready, 0);
      if (x_valid) check("x_rdy", x_ready, 1);
      if (x_valid) check("addr_x_ld", addr_x, xi);
      if (f_valid) check("addr_f_ld", addr_f, fi);
      if (x_valid && x_ready) xi++;
      if (f_valid && f_ready) fi++;
      tick();
      t++;
    end
    x_valid = 1'b0;
    f_valid = 1'b0;
    check("load_bound", t < 200, 1);
    #1;
    check("cmp_x_rdy", x_ready, 0);
    check("cmp_f_rdy", f_ready, 0);
    check("cmp_clr", clear_acc, 0);
  endtask

  task automatic collect(input int n, input int stall_at,
                         input int stall_len, input bit to_load);
    int got = 0;
    int t = 0;
    int cyc = 0;
    int ens = 0;
    int stall = 0;
    bit first = 1'b1;
    logic [2:0] ax;
    logic [1:0] af;
    while (got < n && t < 2000) begin
      y_ready = !(got == stall_at && stall < stall_len);
      #1;
      if (en_acc) ens++;
      if (y_valid) begin
        if (first) begin
          check("y_lat", cyc, FL + 1);
          check("en_cnt", ens, FL);
          ax = addr_x;
          af = addr_f;
          first = 1'b0;
        end else begin
          check("hold_ax", addr_x, ax);
          check("hold_af", addr_f, af);
        end
        check("out_en", en_acc, 0);
        if (y_ready) begin
          check("y", acc, ye[got]);
          check("y_clr", clear_acc, 1);
          if (got == stall_at) check("stall_len", stall, stall_len);
          got++;
          cyc = -1;
          ens = 0;
          first = 1'b1;
        end else begin
          stall++;
        end
      end
      tick();
      t++;
      cyc++;
    end
    y_ready = 1'b0;
    check("y_count", got, n);
    if (to_load) begin
      #1;
      check("reload_x_rdy", x_ready, 1);
      check("reload_f_rdy", f_ready, 1);
      check("reload_yv", y_valid, 0);
    end
  endtask

  initial begin
    reset = 1'b1;
    x_valid = 1'b0;
    f_valid = 1'b0;
    y_ready = 1'b0;
    x_data = '0;
    f_data = '0;
    b_x_valid = 1'b0;
    b_f_valid = 1'b0;
    b_y_ready = 1'b0;
    b_xd = '0;
    b_fd = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check_rst("rst0");

    set1();
    run_load(1'b0, 1'b0);
    collect(YL, -1, 0, 1'b1);

    set2();
    run_load(1'b0, 1'b0);
    collect(YL, -1, 0, 1'b1);

    set1();
    run_load(1'b1, 1'b1);
    collect(YL, 1, 10, 1'b1);

    run_load(1'b0, 1'b0);
    collect(2, -1, 0, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check_rst("rst_cmp");
    set2();
    run_load(1'b0, 1'b0);
    collect(YL, -1, 0, 1'b1);

    set1();
    run_load(1'b0, 1'b0);
    for (int i = 0; i < FL + 1; i++) tick();
    #1;
    check("pend_yv", y_valid, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check_rst("rst_pend");
    tick();
    #1;
    check("pend_gone", y_valid, 0);

    // X_LEN = F_LEN = 4: one output of 1+2+3+4
    for (int i = 0; i < 4; i++) begin
      b_x_valid = 1'b1;
      b_f_valid = 1'b1;
      b_xd = 8'(i + 1);
      b_fd = 8'sd1;
      #1;
      check("b_rdy", b_x_ready & b_f_ready, 1);
      tick();
    end
    b_x_valid = 1'b0;
    b_f_valid = 1'b0;
    b_y_ready = 1'b1;
    begin : b_wait
      int c = 0;
      #1;
      while (!b_y_valid && c < 50) begin
        tick();
        #1;
        c++;
      end
      check("b_lat", c, 5);
      check("b_y", b_acc, 10);
      check("b_clr", b_clr, 1);
      tick();
      #1;
      check("b_load_x", b_x_ready, 1);
      check("b_load_f", b_f_ready, 1);
      check("b_yv", b_y_valid, 0);
    end
    b_y_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
